// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
// A WIDTH-bit word is taken over a valid/ready handshake and shifted out
// LSB-first on sout, one bit per enabled clock, with first/last framing.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// after the data bits. The parity bit then carries last instead of bit WIDTH-1.
//
// Handshake: a word is accepted on a posedge where en, load_valid and
// load_ready are all high. load_ready decodes from registered state only,
// so it never depends on load_valid. d is sampled only on that edge.
// Outputs are pure decodes of registered state, and en=0 freezes everything.
// sclr dominates all other inputs.

module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             sout,
  output logic             sout_valid,
  output logic             first,
  output logic             last
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef PISO_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_SHIFT  = 2'd1
  } state_t;

  // state_q is kept as a named enum so checkers can bind to it directly
  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  logic accept;
  logic last_bit;

  assign accept   = en & load_valid & load_ready;
  assign last_bit = (cnt == LAST_CNT);

  // State register: synchronous reset, otherwise follows next-state logic
  always_ff @(posedge clk) begin
    if (sclr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: only moves on enabled edges
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        ST_IDLE:   if (accept) state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (last_bit) begin
`ifdef PISO_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: load on accept, shift on every enabled SHIFT edge
  always_ff @(posedge clk) begin
    if (sclr) begin
      shreg <= '0;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      shreg <= d;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par   <= ^d;
`endif
    end else if (en && (state_q == ST_SHIFT)) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

  // Output decode from registered state only
  always_comb begin
    sout       = IDLE_LEVEL;
    sout_valid = 1'b0;
    first      = 1'b0;
    last       = 1'b0;
    load_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
      end
      ST_SHIFT: begin
        sout       = shreg[0];
        sout_valid = 1'b1;
        first      = (cnt == '0);
`ifndef PISO_PARITY_EN
        // final data bit closes the frame and can take the next word gaplessly
        last       = last_bit;
        load_ready = last_bit;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        sout       = par;
        sout_valid = 1'b1;
        last       = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: begin
        load_ready = 1'b1;
      end
    endcase
  end

endmodule
